icache_axi_refill: RTL and testbench

ICACHE_AXI_REFILL -- requirements
Module: icache_axi_refill

---
 rtl/icache_axi_refill.sv | 133 +++++++++++++
 tb/tb_icache_axi_refill.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - I-cache line refill engine: one 8-beat AXI4 INCR read per miss
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   refill_req/refill_addr     line-fill request from the icache and miss address
//   refill_addr_ok             one-cycle accept pulse (IDLE only)
//   refill_ret_valid/_data/_err one-cycle line return; data held until next beat 0 write
//   idle                       engine is in IDLE
//   ar*                        AXI4 read address channel (master side)
//   r*                         AXI4 read data channel (master side)
module icache_axi_refill #(
    parameter logic [3:0] AXI_ID     = 4'h0,
    parameter int         LINE_BEATS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         refill_req,
    input  logic [31:0]  refill_addr,
    output logic         refill_addr_ok,
    output logic         refill_ret_valid,
    output logic [255:0] refill_ret_data,
    output logic         refill_ret_err,
    output logic         idle,
    output logic         arvalid,
    input  logic         arready,
    output logic [31:0]  araddr,
    output logic [3:0]   arid,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    input  logic         rvalid,
    output logic         rready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic [3:0]   rid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RET
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     beat_cnt_q, beat_cnt_d;
    logic           err_q, err_d;
    logic [255:0]   data_q, data_d;
    logic           beat_bad;

    // A beat is bad on a non-OKAY response, a foreign ID, or rlast that
    // disagrees with the beat position (expected only on the last beat).
    assign beat_bad = (rresp != 2'b00) || (rid != AXI_ID) ||
                      (rlast != (beat_cnt_q == 3'd7));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (refill_req) begin
                    // Masking keeps the line offset bits out of the burst address.
                    addr_d     = refill_addr & 32'hFFFF_FFE0;
                    beat_cnt_d = 3'd0;
                    err_d      = 1'b0;
                    state_d    = S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    data_d[{beat_cnt_q, 5'b00000} +: 32] = rdata;
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_bad) begin
                        err_d = 1'b1;
                    end
                    // Leave on the eighth beat even if rlast was wrong; the
                    // error flag reports the protocol violation.
                    if (beat_cnt_q == 3'd7) begin
                        state_d = S_RET;
                    end
                end
            end
            S_RET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            beat_cnt_q <= 3'd0;
            err_q      <= 1'b0;
            data_q     <= 256'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    // refill_addr_ok is combinational on refill_req; gating with rst_n keeps
    // it low while reset is asserted.
    assign refill_addr_ok   = rst_n && (state_q == S_IDLE) && refill_req;
    assign idle             = (state_q == S_IDLE);
    assign arvalid          = (state_q == S_AR);
    assign araddr           = addr_q;
    assign arid             = AXI_ID;
    assign arlen            = 8'(LINE_BEATS - 1);
    assign arsize           = 3'b010;
    assign arburst          = 2'b01;
    assign rready           = (state_q == S_R);
    assign refill_ret_valid = (state_q == S_RET);
    assign refill_ret_err   = (state_q == S_RET) && err_q;
    assign refill_ret_data  = data_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb/tb_icache_axi_refill.sv - directed vector bench for icache_axi_refill
module tb_icache_axi_refill;

    logic         clk;
    logic         rst_n;
    logic         refill_req;
    logic [31:0]  refill_addr;
    logic         refill_addr_ok;
    logic         refill_ret_valid;
    logic [255:0] refill_ret_data;
    logic         refill_ret_err;
    logic         idle;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic [3:0]   rid;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    icache_axi_refill #(.AXI_ID(4'h0), .LINE_BEATS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .refill_req       (refill_req),
        .refill_addr      (refill_addr),
        .refill_addr_ok   (refill_addr_ok),
        .refill_ret_valid (refill_ret_valid),
        .refill_ret_data  (refill_ret_data),
        .refill_ret_err   (refill_ret_err),
        .idle             (idle),
        .arvalid          (arvalid),
        .arready          (arready),
        .araddr           (araddr),
        .arid             (arid),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .rvalid           (rvalid),
        .rready           (rready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rid              (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          stall;
        int          gap;
        int          resp_beat;
        int          rlast_beat;
        int          bad_id_beat;
        logic [31:0] base;
        logic [31:0] exp_araddr;
        logic        exp_err;
        logic        hold_req;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_fill(input vec_t v, input int idx);
        int c0;
        int hs;
        refill_req  = 1'b1;
        refill_addr = v.addr;
        arready     = 1'b0;
        rvalid      = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d idle_before", idx), idle, 1);
        check($sformatf("v%0d addr_ok", idx), refill_addr_ok, 1);
        c0 = cyc;
        @(posedge clk); #1;
        refill_req = v.hold_req;
        hs = 0;
        for (int k = 0; k <= v.stall; k++) begin
            arready = (k == v.stall);
            @(negedge clk);
            check($sformatf("v%0d arvalid", idx), arvalid, 1);
            check($sformatf("v%0d araddr", idx), araddr, v.exp_araddr);
            check($sformatf("v%0d arlen", idx), arlen, 8'd7);
            check($sformatf("v%0d arsize", idx), arsize, 3'b010);
            check($sformatf("v%0d arburst", idx), arburst, 2'b01);
            check($sformatf("v%0d arid", idx), arid, 4'h0);
            check($sformatf("v%0d ar_rready", idx), rready, 0);
            check($sformatf("v%0d ar_addr_ok", idx), refill_addr_ok, 0);
            if (arvalid && arready) hs++;
            @(posedge clk); #1;
        end
        arready = 1'b0;
        check($sformatf("v%0d ar_handshakes", idx), hs, 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    rvalid = 1'b0;
                    @(negedge clk);
                    check($sformatf("v%0d stall_rready", idx), rready, 1);
                    check($sformatf("v%0d stall_ret_valid", idx), refill_ret_valid, 0);
                    @(posedge clk); #1;
                end
            end
            rvalid = 1'b1;
            rdata  = v.base + 32'(i);
            rresp  = (i == v.resp_beat) ? 2'b10 : 2'b00;
            rid    = (i == v.bad_id_beat) ? 4'h5 : 4'h0;
            rlast  = (i == v.rlast_beat);
            @(negedge clk);
            check($sformatf("v%0d b%0d rready", idx, i), rready, 1);
            check($sformatf("v%0d b%0d arvalid", idx, i), arvalid, 0);
            check($sformatf("v%0d b%0d ret_valid", idx, i), refill_ret_valid, 0);
            check($sformatf("v%0d b%0d addr_ok", idx, i), refill_addr_ok, 0);
            check($sformatf("v%0d b%0d idle", idx, i), idle, 0);
            @(posedge clk); #1;
        end
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = 2'b00;
        rid        = 4'h0;
        refill_req = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d ret_valid", idx), refill_ret_valid, 1);
        check($sformatf("v%0d ret_err", idx), refill_ret_err, v.exp_err);
        check($sformatf("v%0d latency", idx), cyc - c0, 10 + v.stall + 7 * v.gap);
        check($sformatf("v%0d ret_rready", idx), rready, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d word%0d", idx, i), refill_ret_data[32*i +: 32], v.base + 32'(i));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d post_ret_valid", idx), refill_ret_valid, 0);
        check($sformatf("v%0d post_ret_err", idx), refill_ret_err, 0);
        check($sformatf("v%0d post_idle", idx), idle, 1);
        check($sformatf("v%0d post_word7", idx), refill_ret_data[255:224], v.base + 32'd7);
        @(posedge clk); #1;
    endtask

    initial begin
        //            addr          stall gap resp rlast badid base          exp_araddr    err   hold
        vecs[0] = '{32'h1C00_0014, 0, 0, -1, 7, -1, 32'h0000_0100, 32'h1C00_0000, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_103F, 5, 0, -1, 7, -1, 32'h0000_A000, 32'h8000_1020, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0020, 0, 2, -1, 7, -1, 32'h0000_5500, 32'h0000_0020, 1'b0, 1'b0};
        vecs[3] = '{32'h1234_5678, 0, 0,  3, 7, -1, 32'hBEEF_0000, 32'h1234_5660, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 0, 0, -1, 7, -1, 32'h0000_3300, 32'hFFFF_FFE0, 1'b0, 1'b1};
        vecs[5] = '{32'h4000_0000, 1, 0, -1, 5, -1, 32'h0000_6600, 32'h4000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_1000, 2, 1, -1, 7,  0, 32'h0000_7700, 32'h0000_1000, 1'b1, 1'b0};
        vecs[7] = '{32'h2000_0044, 0, 0, -1, 7, -1, 32'h0000_9900, 32'h2000_0040, 1'b0, 1'b0};

        rst_n       = 1'b0;
        refill_req  = 1'b1;
        refill_addr = 32'h1111_1111;
        arready     = 1'b1;
        rvalid      = 1'b1;
        rdata       = 32'hDEAD_BEEF;
        rresp       = 2'b00;
        rlast       = 1'b0;
        rid         = 4'h0;
        @(negedge clk);
        check("rst idle", idle, 1);
        check("rst addr_ok", refill_addr_ok, 0);
        check("rst arvalid", arvalid, 0);
        check("rst rready", rready, 0);
        check("rst ret_valid", refill_ret_valid, 0);
        check("rst ret_err", refill_ret_err, 0);
        check("rst ret_data", refill_ret_data[31:0], 0);
        check("rst araddr", araddr, 0);
        refill_req = 1'b0;
        rvalid     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 8; n++) begin
            do_fill(vecs[n], n);
        end

        // Reset during beat 4 of a burst, with stale beats after release.
        refill_req  = 1'b1;
        refill_addr = 32'h3000_0008;
        arready     = 1'b1;
        @(posedge clk); #1;
        refill_req = 1'b0;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1;
            rdata  = 32'h7770 + 32'(i);
            rlast  = 1'b0;
            @(posedge clk); #1;
        end
        rdata      = 32'h7774;
        refill_req = 1'b1;
        rst_n      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mid_rst idle", idle, 1);
            check("mid_rst addr_ok", refill_addr_ok, 0);
            check("mid_rst rready", rready, 0);
            check("mid_rst arvalid", arvalid, 0);
            check("mid_rst ret_valid", refill_ret_valid, 0);
            check("mid_rst ret_err", refill_ret_err, 0);
            check("mid_rst ret_data", refill_ret_data[31:0], 0);
            check("mid_rst ret_data_hi", refill_ret_data[255:224], 0);
            @(posedge clk); #1;
        end
        refill_req = 1'b0;
        rst_n      = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rdata = 32'h5000 + 32'(k);
            rlast = (k == 3);
            @(negedge clk);
            check("stale idle", idle, 1);
            check("stale rready", rready, 0);
            check("stale ret_valid", refill_ret_valid, 0);
            check("stale ret_data", refill_ret_data[63:0], 0);
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        do_fill(vecs[7], 8);
        do_fill(vecs[0], 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
